vp_validation_queue: RTL and testbench
======================================

Name: vp_validation_queue

Overview:
- In-order buffer directly downstream of the value predictor.
- Captures every valid prediction (pc, predicted value, confidence) as it leaves the predictor and holds it until the matching execution result returns in program order.
- Compares the stored prediction against the actual result and drives the predictor's feedback interface (pc, actual, mispredict, conf, valid) one cycle later.
- Also raises a stall request and a replay indication for the core pipeline.

Parameters:
- P_QUEUE_DEPTH, 32: number of in-flight predictions; power of 2, >= 4.
- P_CONF_WIDTH, 8: confidence counter width is P_CONF_WIDTH+1 bits; MSB set = saturated.
- P_NUM_PRED, 2: lanes per cycle; legal values are 1 and 2. Lane 0 is always older than lane 1.

Ports:
- clk_i  in  1  main clock
- rst_i  in  1  synchronous active-high reset
- pred_pc_i  in  [P_NUM_PRED-1:0][31:1]  predicted instruction pc
- pred_result_i  in  [P_NUM_PRED-1:0][31:0]  predicted value
- pred_conf_i  in  [P_NUM_PRED-1:0][P_CONF_WIDTH:0]  confidence at prediction time
- pred_valid_i  in  [P_NUM_PRED-1:0]  per-lane prediction qualifier
- ex_actual_i  in  [P_NUM_PRED-1:0][31:0]  executed result, program order
- ex_valid_i  in  [P_NUM_PRED-1:0]  per-lane result qualifier
- flush_i  in  1  pipeline squash; discards all entries
- stall_o  out  1  free entries < P_NUM_PRED
- overflow_o  out  1  one-cycle pulse: at least one prediction dropped
- underflow_o  out  1  one-cycle pulse: at least one result had no entry
- replay_o  out  [P_NUM_PRED-1:0]  mispredict while stored conf was saturated
- fb_pc_o  out  [P_NUM_PRED-1:0][31:1]  feedback pc
- fb_actual_o  out  [P_NUM_PRED-1:0][31:0]  feedback actual value
- fb_mispredict_o  out  [P_NUM_PRED-1:0]  predicted != actual
- fb_conf_o  out  [P_NUM_PRED-1:0][P_CONF_WIDTH:0]  stored confidence, returned unmodified
- fb_valid_o  out  [P_NUM_PRED-1:0]  feedback qualifier

Behaviour:
- Storage and counters:
  - Circular buffer with head (oldest) and tail pointers, each $clog2(P_QUEUE_DEPTH) bits; pointers wrap modulo depth.
  - Occupancy count is $clog2(P_QUEUE_DEPTH+1) bits.
- Reset (rst_i=1 at a clock edge):
  - head, tail and count go to 0.
  - All outputs go to 0 on the next cycle: fb_*, replay_o, overflow_o, underflow_o and stall_o.
  - Storage contents are don't-care.
- Enqueue:
  - Valid pred lanes are compacted in lane order into slots tail, tail+1.
  - A pattern of 2'b10 writes lane 1 at tail.
  - Lanes are accepted oldest-first up to the free-entry count. Excess lanes are dropped and overflow_o pulses the next cycle.
- Dequeue:
  - Valid ex lanes are compacted in lane order; the k-th valid result pairs with entry head+k.
  - If k >= count (count sampled at the start of the cycle), that result is discarded and underflow_o pulses next cycle.
  - An entry written in the same cycle is never visible to a same-cycle dequeue.
- Compare and feedback timing:
  - mispredict = (stored result != ex_actual). This is a full 32-bit compare, independent of confidence.
  - Feedback is registered, latency exactly 1 cycle: ex_valid at cycle N gives fb_valid_o at N+1.
  - fb lanes are compacted: the first popped entry drives lane 0.
  - fb_pc_o and fb_conf_o come from the stored entry; fb_actual_o is ex_actual_i.
  - replay_o[i] = fb_valid_o[i] & fb_mispredict_o[i] & fb_conf_o[i][P_CONF_WIDTH], aligned with fb.
- Occupancy:
  - Simultaneous enqueue and dequeue: count_next = count + accepted − popped.
  - Full and empty are derived from count, not from pointer equality.
- stall_o:
  - Registered, computed from count_next: asserted when P_QUEUE_DEPTH − count_next < P_NUM_PRED.
- flush_i:
  - Synchronous. head, tail and count go to 0.
  - Same-cycle enqueues and dequeues are ignored; no overflow or underflow pulses are produced.
  - fb_valid_o and replay_o are 0 on the next cycle.
  - rst_i has priority over flush_i.
- P_NUM_PRED=1: lane logic collapses; behaviour is otherwise identical.

Test Plan:
- Basic round trip: reset, then pred lane0 pc=0x100, result=0x5, conf=9'h100. Next cycle ex lane0 actual=0x5 → at N+1, fb_valid_o=01, fb_pc_o[0]=0x100, fb_mispredict_o=0, fb_conf_o=9'h100, replay_o=00.
- Mispredict with saturated confidence: preds 2'b11, (0x200, 0x7, conf 9'h1FF) and (0x204, 0x8, conf 9'h003); results 0x7 and 0x9 → fb_mispredict_o=10, replay_o=00 (lane 1 conf not saturated). Repeat with lane 1 conf 9'h100 → replay_o=10.
- Fill and wrap: enqueue 2/cycle for 16 cycles (DEPTH=32) → stall_o=1 once count=31 or 32. A 17th enqueue of 2'b11 → both dropped, overflow_o pulse. Then drain 40 results → 32 feedbacks in order, underflow_o pulses, head wraps to 0.
- Concurrent enqueue and dequeue at count=1: enqueue 2 and dequeue 2 in the same cycle → 1 popped, 1 underflow, count=2 after.
- Sparse lanes: pred 2'b10 at 0x300, then ex 2'b10 → fb_valid_o=01 with fb_pc_o[0]=0x300.
- Flush mid-stream: 5 entries, flush_i asserted with ex_valid=11 → fb_valid_o=00 next cycle, count=0, no underflow or overflow pulse. Reset asserted during the same test → all outputs 0.

Source files
------------

// File: rtl/vp_validation_queue.sv
// In-order validation buffer that sits behind the value predictor.
// Holds each issued prediction (pc, value, confidence) until its execution
// result returns in program order. It then drives registered predictor
// feedback, a replay request, and the stall, overflow and underflow flags.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   pred_*_i            per-lane prediction capture (pc, value, conf, valid)
//   ex_actual_i/valid_i per-lane executed results, program order
//   flush_i             squash: empties the queue, ignores same-cycle traffic
//   stall_o             fewer than P_NUM_PRED free entries after this cycle
//   overflow_o          pulse: a valid prediction found no free entry
//   underflow_o         pulse: a valid result found no stored entry
//   replay_o            mispredict on an entry whose stored conf was saturated
//   fb_*_o              compacted predictor feedback, one cycle after ex_valid
module vp_validation_queue #(
  parameter int unsigned P_QUEUE_DEPTH = 32,
  parameter int unsigned P_CONF_WIDTH  = 8,
  parameter int unsigned P_NUM_PRED    = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [P_NUM_PRED-1:0][31:1]              pred_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]              pred_result_i,
  input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]    pred_conf_i,
  input  logic [P_NUM_PRED-1:0]                    pred_valid_i,
  input  logic [P_NUM_PRED-1:0][31:0]              ex_actual_i,
  input  logic [P_NUM_PRED-1:0]                    ex_valid_i,
  input  logic                                     flush_i,
  output logic                                     stall_o,
  output logic                                     overflow_o,
  output logic                                     underflow_o,
  output logic [P_NUM_PRED-1:0]                    replay_o,
  output logic [P_NUM_PRED-1:0][31:1]              fb_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]              fb_actual_o,
  output logic [P_NUM_PRED-1:0]                    fb_mispredict_o,
  output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]    fb_conf_o,
  output logic [P_NUM_PRED-1:0]                    fb_valid_o
);

  localparam int unsigned PTR_W  = $clog2(P_QUEUE_DEPTH);
  localparam int unsigned CNT_W  = $clog2(P_QUEUE_DEPTH + 1);
  localparam int unsigned CONF_W = P_CONF_WIDTH + 1;

  // Entry storage; contents are don't-care out of reset
  logic [31:1]       r_pc_mem   [P_QUEUE_DEPTH];
  logic [31:0]       r_res_mem  [P_QUEUE_DEPTH];
  logic [CONF_W-1:0] r_conf_mem [P_QUEUE_DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_enq_cnt;
  logic [CNT_W-1:0]  w_pop_cnt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_enq_rank [P_NUM_PRED];
  logic [CNT_W-1:0]  w_ex_rank  [P_NUM_PRED];
  logic [P_NUM_PRED-1:0] w_enq_acc;
  logic [P_NUM_PRED-1:0] w_ex_hit;
  logic              w_ovf;
  logic              w_unf;
  logic              w_stall_nxt;

  logic [PTR_W-1:0]                  w_rd_idx [P_NUM_PRED];
  logic [P_NUM_PRED-1:0]             w_fb_valid;
  logic [P_NUM_PRED-1:0][31:1]       w_fb_pc;
  logic [P_NUM_PRED-1:0][31:0]       w_fb_actual;
  logic [P_NUM_PRED-1:0]             w_fb_misp;
  logic [P_NUM_PRED-1:0][CONF_W-1:0] w_fb_conf;
  logic [P_NUM_PRED-1:0]             w_replay;

  // Enqueue: compact valid lanes oldest-first, accept up to the free count
  always_comb begin
    w_free    = CNT_W'(P_QUEUE_DEPTH) - r_count;
    w_enq_cnt = '0;
    w_enq_acc = '0;
    w_ovf     = 1'b0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      w_enq_rank[i] = w_enq_cnt;
      if (pred_valid_i[i] && !flush_i) begin
        if (w_enq_cnt < w_free) begin
          w_enq_acc[i] = 1'b1;
          w_enq_cnt    = w_enq_cnt + CNT_W'(1);
        end else begin
          w_ovf = 1'b1;
        end
      end
    end
  end

  // Dequeue: k-th valid result pairs with head+k; only start-of-cycle
  // occupancy is visible, so same-cycle writes can never be popped
  always_comb begin
    w_pop_cnt = '0;
    w_ex_hit  = '0;
    w_unf     = 1'b0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      w_ex_rank[i] = w_pop_cnt;
      if (ex_valid_i[i] && !flush_i) begin
        if (w_pop_cnt < r_count) begin
          w_ex_hit[i] = 1'b1;
          w_pop_cnt   = w_pop_cnt + CNT_W'(1);
        end else begin
          w_unf = 1'b1;
        end
      end
    end
  end

  // Occupancy and stall look-ahead
  always_comb begin
    w_count_nxt = flush_i ? '0 : (r_count + w_enq_cnt - w_pop_cnt);
    w_stall_nxt = (CNT_W'(P_QUEUE_DEPTH) - w_count_nxt) < CNT_W'(P_NUM_PRED);
  end

  // Feedback lane k takes the result ranked k and the entry at head+k
  always_comb begin
    w_fb_valid  = '0;
    w_fb_pc     = '0;
    w_fb_actual = '0;
    w_fb_misp   = '0;
    w_fb_conf   = '0;
    w_replay    = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      w_rd_idx[k] = r_head + PTR_W'(k);
      for (int i = 0; i < P_NUM_PRED; i++) begin
        if (w_ex_hit[i] && (w_ex_rank[i] == CNT_W'(k))) begin
          w_fb_valid[k]  = 1'b1;
          w_fb_actual[k] = ex_actual_i[i];
        end
      end
      if (w_fb_valid[k]) begin
        w_fb_pc[k]   = r_pc_mem[w_rd_idx[k]];
        w_fb_conf[k] = r_conf_mem[w_rd_idx[k]];
        w_fb_misp[k] = (r_res_mem[w_rd_idx[k]] != w_fb_actual[k]);
        w_replay[k]  = w_fb_misp[k] & w_fb_conf[k][CONF_W-1];
      end
    end
  end

  // Pointer and count state; reset outranks flush
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_cnt);
      r_tail  <= r_tail + PTR_W'(w_enq_cnt);
      r_count <= w_count_nxt;
    end
  end

  // Entry writes, compacted from tail
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < P_NUM_PRED; i++) begin
      if (!rst_i && w_enq_acc[i]) begin
        r_pc_mem  [r_tail + PTR_W'(w_enq_rank[i])] <= pred_pc_i[i];
        r_res_mem [r_tail + PTR_W'(w_enq_rank[i])] <= pred_result_i[i];
        r_conf_mem[r_tail + PTR_W'(w_enq_rank[i])] <= pred_conf_i[i];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_o         <= 1'b0;
      overflow_o      <= 1'b0;
      underflow_o     <= 1'b0;
      replay_o        <= '0;
      fb_pc_o         <= '0;
      fb_actual_o     <= '0;
      fb_mispredict_o <= '0;
      fb_conf_o       <= '0;
      fb_valid_o      <= '0;
    end else begin
      stall_o         <= w_stall_nxt;
      overflow_o      <= w_ovf;
      underflow_o     <= w_unf;
      replay_o        <= w_replay;
      fb_pc_o         <= w_fb_pc;
      fb_actual_o     <= w_fb_actual;
      fb_mispredict_o <= w_fb_misp;
      fb_conf_o       <= w_fb_conf;
      fb_valid_o      <= w_fb_valid;
    end
  end

endmodule

// File: tb/tb_vp_validation_queue.sv
// Directed bench for vp_validation_queue (DEPTH=32, CONF_WIDTH=8, 2 lanes).
module tb_vp_validation_queue;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = 8;
  localparam int unsigned NP    = 2;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b1;
  logic [NP-1:0][31:1]    pred_pc_i = '0;
  logic [NP-1:0][31:0]    pred_result_i = '0;
  logic [NP-1:0][CW:0]    pred_conf_i = '0;
  logic [NP-1:0]          pred_valid_i = '0;
  logic [NP-1:0][31:0]    ex_actual_i = '0;
  logic [NP-1:0]          ex_valid_i = '0;
  logic                   flush_i = 1'b0;
  logic                   stall_o;
  logic                   overflow_o;
  logic                   underflow_o;
  logic [NP-1:0]          replay_o;
  logic [NP-1:0][31:1]    fb_pc_o;
  logic [NP-1:0][31:0]    fb_actual_o;
  logic [NP-1:0]          fb_mispredict_o;
  logic [NP-1:0][CW:0]    fb_conf_o;
  logic [NP-1:0]          fb_valid_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vp_validation_queue #(
    .P_QUEUE_DEPTH(DEPTH),
    .P_CONF_WIDTH (CW),
    .P_NUM_PRED   (NP)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pred_pc_i      (pred_pc_i),
    .pred_result_i  (pred_result_i),
    .pred_conf_i    (pred_conf_i),
    .pred_valid_i   (pred_valid_i),
    .ex_actual_i    (ex_actual_i),
    .ex_valid_i     (ex_valid_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .replay_o       (replay_o),
    .fb_pc_o        (fb_pc_o),
    .fb_actual_o    (fb_actual_o),
    .fb_mispredict_o(fb_mispredict_o),
    .fb_conf_o      (fb_conf_o),
    .fb_valid_o     (fb_valid_o)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic [1:0]  pv;
    logic [31:1] pc0;
    logic [31:0] r0;
    logic [8:0]  c0;
    logic [31:1] pc1;
    logic [31:0] r1;
    logic [8:0]  c1;
    logic [1:0]  ev;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  e_fv;
    logic [1:0]  e_mp;
    logic [1:0]  e_rp;
    logic        e_ovf;
    logic        e_unf;
    logic        e_stall;
    logic [31:1] e_pc0;
    logic [8:0]  e_c0;
    logic [31:0] e_a0;
    logic [31:1] e_pc1;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic rst, input logic flush, input logic [1:0] pv,
                       input logic [31:1] pc0, input logic [31:0] r0, input logic [8:0] c0,
                       input logic [31:1] pc1, input logic [31:0] r1, input logic [8:0] c1,
                       input logic [1:0] ev, input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    rst_i            = rst;
    flush_i          = flush;
    pred_valid_i     = pv;
    pred_pc_i[0]     = pc0;
    pred_result_i[0] = r0;
    pred_conf_i[0]   = c0;
    pred_pc_i[1]     = pc1;
    pred_result_i[1] = r1;
    pred_conf_i[1]   = c1;
    ex_valid_i       = ev;
    ex_actual_i[0]   = a0;
    ex_actual_i[1]   = a1;
  endtask

  // Samples 1 time unit after the edge that registers the driven inputs
  task automatic check(input string name, input logic [1:0] fv, input logic [1:0] mp,
                       input logic [1:0] rp, input logic ovf, input logic unf, input logic stl,
                       input logic [31:1] pc0, input logic [8:0] c0, input logic [31:0] a0,
                       input logic [31:1] pc1);
    logic ok;
    @(posedge clk);
    #1;
    ok = 1'b1;
    if (fb_valid_o !== fv) ok = 1'b0;
    if ((fb_mispredict_o & fv) !== mp) ok = 1'b0;
    if (replay_o !== rp) ok = 1'b0;
    if (overflow_o !== ovf || underflow_o !== unf || stall_o !== stl) ok = 1'b0;
    if (fv[0] && (fb_pc_o[0] !== pc0 || fb_conf_o[0] !== c0 || fb_actual_o[0] !== a0)) ok = 1'b0;
    if (fv[1] && fb_pc_o[1] !== pc1) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got fv=%b mp=%b rp=%b ovf=%b unf=%b stall=%b pc0=%h c0=%h a0=%h pc1=%h | exp fv=%b mp=%b rp=%b ovf=%b unf=%b stall=%b pc0=%h c0=%h a0=%h pc1=%h",
               name, fb_valid_o, fb_mispredict_o, replay_o, overflow_o, underflow_o, stall_o,
               fb_pc_o[0], fb_conf_o[0], fb_actual_o[0], fb_pc_o[1],
               fv, mp, rp, ovf, unf, stl, pc0, c0, a0, pc1);
    end
  endtask

  initial begin
    // name rst fl pv | pc0 r0 c0 | pc1 r1 c1 | ev a0 a1 | fv mp rp ovf unf stall | pc0 c0 a0 pc1
    tbl.push_back('{"reset", 1'b1, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"rt_enq", 1'b0, 1'b0, 2'b01, 31'h100, 32'h5, 9'h100, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"rt_fb", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b01, 32'h5, 32'h0,
                    2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h100, 9'h100, 32'h5, 31'h0});
    tbl.push_back('{"sat_enq", 1'b0, 1'b0, 2'b11, 31'h200, 32'h7, 9'h1FF, 31'h204, 32'h8, 9'h003, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"sat_fb", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b11, 32'h7, 32'h9,
                    2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 31'h200, 9'h1FF, 32'h7, 31'h204});
    tbl.push_back('{"sat2_enq", 1'b0, 1'b0, 2'b11, 31'h200, 32'h7, 9'h1FF, 31'h204, 32'h8, 9'h100, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"sat2_fb", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b11, 32'h7, 32'h9,
                    2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 31'h200, 9'h1FF, 32'h7, 31'h204});
    tbl.push_back('{"l0_enq", 1'b0, 1'b0, 2'b01, 31'h210, 32'hA, 9'h1FF, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"l0_fb", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b01, 32'hB, 32'h0,
                    2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 31'h210, 9'h1FF, 32'hB, 31'h0});
    tbl.push_back('{"sparse_enq", 1'b0, 1'b0, 2'b10, 31'h0, 32'h0, 9'h0, 31'h300, 32'h33, 9'h003, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"sparse_fb", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b10, 32'h0, 32'h33,
                    2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h300, 9'h003, 32'h33, 31'h0});
    tbl.push_back('{"empty_unf", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b01, 32'h1, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"conc_pre", 1'b0, 1'b0, 2'b01, 31'h400, 32'h1, 9'h0, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"conc", 1'b0, 1'b0, 2'b11, 31'h404, 32'h2, 9'h0, 31'h408, 32'h3, 9'h0, 2'b11, 32'h1, 32'h1,
                    2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 31'h400, 9'h0, 32'h1, 31'h0});
    tbl.push_back('{"conc_drain", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b11, 32'h2, 32'h99,
                    2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 31'h404, 9'h0, 32'h2, 31'h408});
    tbl.push_back('{"fl_enq1", 1'b0, 1'b0, 2'b11, 31'h600, 32'h1, 9'h1FF, 31'h604, 32'h2, 9'h1FF, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"fl_enq2", 1'b0, 1'b0, 2'b11, 31'h608, 32'h3, 9'h1FF, 31'h60C, 32'h4, 9'h1FF, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"fl_enq3", 1'b0, 1'b0, 2'b01, 31'h610, 32'h5, 9'h1FF, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"flush", 1'b0, 1'b1, 2'b11, 31'h614, 32'h6, 9'h0, 31'h618, 32'h7, 9'h0, 2'b11, 32'hF0, 32'hF1,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"post_flush", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b01, 32'h1, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"rs_enq", 1'b0, 1'b0, 2'b11, 31'h700, 32'h1, 9'h1FF, 31'h704, 32'h2, 9'h1FF, 2'b00, 32'h0, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"rs_mid", 1'b1, 1'b1, 2'b11, 31'h708, 32'h1, 9'h0, 31'h70C, 32'h1, 9'h0, 2'b11, 32'h9, 32'h9,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});
    tbl.push_back('{"post_rst", 1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b01, 32'h1, 32'h0,
                    2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0});

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].flush, tbl[n].pv, tbl[n].pc0, tbl[n].r0, tbl[n].c0,
            tbl[n].pc1, tbl[n].r1, tbl[n].c1, tbl[n].ev, tbl[n].a0, tbl[n].a1);
      check(tbl[n].name, tbl[n].e_fv, tbl[n].e_mp, tbl[n].e_rp, tbl[n].e_ovf, tbl[n].e_unf,
            tbl[n].e_stall, tbl[n].e_pc0, tbl[n].e_c0, tbl[n].e_a0, tbl[n].e_pc1);
    end

    // Fill from empty (pointers at 0 after reset): stall only once count hits 32
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 1'b0, 2'b11, 31'(32'h1000 + 8 * c), 32'(2 * c), 9'h0,
            31'(32'h1004 + 8 * c), 32'(2 * c + 1), 9'h0, 2'b00, 32'h0, 32'h0);
      check("fill", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, (c == 15), 31'h0, 9'h0, 32'h0, 31'h0);
    end

    // Full queue drops both lanes
    drive(1'b0, 1'b0, 2'b11, 31'h1F00, 32'hAA, 9'h0, 31'h1F04, 32'hBB, 9'h0, 2'b00, 32'h0, 32'h0);
    check("full_ovf", 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 31'h0, 9'h0, 32'h0, 31'h0);

    // Drain 40 results: 32 in-order feedbacks then underflow
    for (int d = 0; d < 20; d++) begin
      drive(1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b11,
            32'(2 * d), (d == 3) ? 32'hDEAD : 32'(2 * d + 1));
      if (d < 16)
        check("drain", 2'b11, (d == 3) ? 2'b10 : 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,
              31'(32'h1000 + 8 * d), 9'h0, 32'(2 * d), 31'(32'h1004 + 8 * d));
      else
        check("drain_unf", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0);
    end

    // Head and tail have wrapped back to slot 0
    drive(1'b0, 1'b0, 2'b01, 31'h500, 32'h55, 9'h180, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0);
    check("wrap_enq", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0);
    drive(1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b01, 32'h56, 32'h0);
    check("wrap_fb", 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 31'h500, 9'h180, 32'h56, 31'h0);

    drive(1'b0, 1'b0, 2'b00, 31'h0, 32'h0, 9'h0, 31'h0, 32'h0, 9'h0, 2'b00, 32'h0, 32'h0);
    check("idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 31'h0, 9'h0, 32'h0, 31'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
